// File: rtl/fb_scanout.sv
// Scans the CHIP-8 64x32 framebuffer out of block RAM and re-emits it as a
// 256-byte SSD1306 page/column stream behind a valid/ready handshake.
module fb_scanout #(
  parameter logic [11:0] FB_BASE = 12'h100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WAIT = 2'd2, EMIT = 2'd3} state_t;

  state_t      state_r, state_s;
  logic [1:0]  page_r, page_s;
  logic [2:0]  group_r, group_s;
  logic [2:0]  row_r, row_s;
  logic [2:0]  col_r, col_s;
  logic [63:0] block_r;
  logic        busy_s, mem_rd_s, out_valid_s, out_last_s;
  logic [11:0] mem_addr_s;
  logic [7:0]  out_data_s;
  logic        final_group_s;

  // Row k of 8-byte group g on page p sits at FB_BASE + 64p + 8k + g.
  function automatic logic [11:0] rd_addr(input logic [1:0] p, input logic [2:0] k,
                                          input logic [2:0] g);
    rd_addr = FB_BASE + {4'd0, p, k, g};
  endfunction

  // Bit i of the display byte is pixel column c (MSB-left) of captured row i.
  function automatic logic [7:0] column(input logic [63:0] rows, input logic [2:0] c);
    logic [7:0] b;
    b = 8'd0;
    for (int i = 0; i < 8; i++) begin
      b[i] = rows[{i[2:0], ~c}];
    end
    column = b;
  endfunction

  assign final_group_s = (page_r == 2'd3) && (group_r == 3'd7);

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_s     = state_r;
    page_s      = page_r;
    group_s     = group_r;
    row_s       = row_r;
    col_s       = col_r;
    busy_s      = busy;
    mem_rd_s    = 1'b0;
    mem_addr_s  = mem_addr;
    out_valid_s = out_valid;
    out_data_s  = out_data;
    out_last_s  = out_last;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s    = READ;
          page_s     = 2'd0;
          group_s    = 3'd0;
          row_s      = 3'd0;
          busy_s     = 1'b1;
          mem_rd_s   = 1'b1;
          mem_addr_s = rd_addr(2'd0, 3'd0, 3'd0);
        end else begin
          busy_s      = 1'b0;
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
        end
      end
      READ: begin
        if (row_r == 3'd7) begin
          state_s = WAIT;
        end else begin
          row_s      = row_r + 3'd1;
          mem_rd_s   = 1'b1;
          mem_addr_s = rd_addr(page_r, row_r + 3'd1, group_r);
        end
      end
      WAIT: begin
        // Row 7 arrives this cycle, so feed it straight into column 0.
        state_s     = EMIT;
        col_s       = 3'd0;
        out_valid_s = 1'b1;
        out_data_s  = column({mem_data, block_r[55:0]}, 3'd0);
        out_last_s  = 1'b0;
      end
      EMIT: begin
        if (out_ready) begin
          if (col_r == 3'd7) begin
            out_valid_s = 1'b0;
            out_last_s  = 1'b0;
            if (final_group_s) begin
              state_s = IDLE;
              busy_s  = 1'b0;
              page_s  = 2'd0;
              group_s = 3'd0;
            end else begin
              state_s    = READ;
              group_s    = group_r + 3'd1;
              page_s     = (group_r == 3'd7) ? page_r + 2'd1 : page_r;
              row_s      = 3'd0;
              mem_rd_s   = 1'b1;
              mem_addr_s = rd_addr((group_r == 3'd7) ? page_r + 2'd1 : page_r, 3'd0,
                                   group_r + 3'd1);
            end
          end else begin
            col_s      = col_r + 3'd1;
            out_data_s = column(block_r, col_r + 3'd1);
            out_last_s = final_group_s && (col_r == 3'd6);
          end
        end else begin
          col_s = col_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      page_r    <= 2'd0;
      group_r   <= 3'd0;
      row_r     <= 3'd0;
      col_r     <= 3'd0;
      busy      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= 12'd0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_last  <= 1'b0;
    end else begin
      state_r   <= state_s;
      page_r    <= page_s;
      group_r   <= group_s;
      row_r     <= row_s;
      col_r     <= col_s;
      busy      <= busy_s;
      mem_rd    <= mem_rd_s;
      mem_addr  <= mem_addr_s;
      out_valid <= out_valid_s;
      out_data  <= out_data_s;
      out_last  <= out_last_s;
    end
  end

  // Capture read data one cycle behind each read; row 7 lands during WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      block_r <= 64'd0;
    end else if ((state_r == READ) && (row_r != 3'd0)) begin
      block_r[{row_r - 3'd1, 3'b000} +: 8] <= mem_data;
    end else if (state_r == WAIT) begin
      block_r[63:56] <= mem_data;
    end
  end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Reads the CHIP-8 64x32 monochrome framebuffer from its dedicated read port on the shared block RAM. The CPU writes the framebuffer at 0x100-0x1FF through the other port.
- Re-emits the frame as a 256-byte stream in SSD1306 page/column order for the display driver.
- A frame is triggered by `start`. Output uses a valid/ready handshake, so the downstream SPI/I2C shifter can throttle it.

Parameters:
- FB_BASE, 12'h100, base address of the framebuffer in CPU memory.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to scan one frame; ignored while busy
- busy  out  1  high from the cycle after an accepted start until the frame's last byte is transferred
- mem_addr  out  12  framebuffer read address
- mem_rd  out  1  read enable; memory returns data on mem_data the following cycle
- mem_data  in  8  read data, valid exactly one cycle after mem_rd
- out_valid  out  1  out_data holds a valid byte
- out_ready  in  1  consumer accepts; a byte transfers when out_valid && out_ready
- out_data  out  8  display byte
- out_last  out  1  high with the 256th (final) byte of the frame

Behaviour:
- Framebuffer layout:
  - pixel (x,y), x 0-63, y 0-31, lives at address FB_BASE + y*8 + x/8.
  - Bit position is 7-(x%8), so the MSB is the leftmost pixel.
- Output order: page p = 0..3; within each page, column x = 0..63.
  - Byte bit i (i = 0..7) = pixel (x, 8p+i); bit0 is the top row of the page.
  - Byte index = p*64 + x.
- Reset: state IDLE; busy, mem_rd, out_valid and out_last = 0; out_data = 0, mem_addr = 0; counters cleared.
- States: IDLE, READ, WAIT, EMIT.
- IDLE:
  - start=1 → READ; group counter (page p 2b, byte-group g 3b) = 0.
  - busy goes high in the next cycle.
- READ: 8 cycles, row index k = 0..7.
  - Drives mem_rd=1 and mem_addr = FB_BASE + (8p+k)*8 + g.
  - The data returned the following cycle is captured into block[k].
  - After k=7 → WAIT.
- WAIT: 1 cycle.
  - mem_rd=0; captures block[7].
  - → EMIT with column c = 0.
- EMIT:
  - out_valid=1; out_data bit i = block[i][7-c].
  - On transfer: c increments. At c=7, g increments and the state returns to READ.
  - When g wraps 7→0, p increments.
  - Transfer of byte 255 (p=3, g=7, c=7) → IDLE. busy and out_valid are 0 in the next cycle.
- Handshake rules:
  - out_valid is never withdrawn before transfer.
  - out_data and out_last are stable while out_valid && !out_ready.
  - out_valid never depends combinationally on out_ready.
- Outside READ, mem_rd=0. mem_addr is don't-care when mem_rd=0 (it holds its last value).
- Timing with out_ready tied to 1, start sampled at edge 0:
  - First mem_rd in cycle 1; first out_valid in cycle 10.
  - 17 cycles per 8-byte group; last transfer in cycle 544; busy low from cycle 545.
- start while busy: ignored, no queueing. start coincident with the final transfer is also ignored.
- Reset mid-frame: abandons the frame immediately and all outputs take their reset values. The next start begins again at byte 0.
- The block never writes memory. Tearing caused by the CPU writing during a scan is acceptable.

Test Plan:
- All-zero framebuffer; start; out_ready=1 → exactly 256 transfers, all 0x00. out_last only on the 256th. busy drops at cycle 545 and first out_valid appears at cycle 10.
- mem[0x100]=0x80 (pixel 0,0) → byte 0 = 0x01, all others 0x00. mem[0x1FF]=0x01 (pixel 63,31) → byte 255 = 0x80, all others 0x00.
- mem[0x100..0x107]=0xFF (row 0 lit) → bytes 0..63 = 0x01, bytes 64..255 = 0x00. mem[0x101+8y]=0x80 for all y (column 8 lit) → bytes 8, 72, 136, 200 = 0xFF, all others 0x00.
- Random framebuffer with out_ready driven by an LFSR (~50% duty) → stream matches a software transpose model byte-for-byte. out_data and out_last are stable across every stalled cycle; no byte is dropped or duplicated.
- Re-pulse start at bytes 3 and 100 during a frame → no effect; still exactly 256 bytes. A new start after busy falls produces a second identical frame.
- Assert reset for 1 cycle after byte 40 → out_valid, busy and mem_rd are 0 in the next cycle. A subsequent start yields byte 0 first and a full 256-byte frame.
